icache_sa: RTL

ICACHE_SA -- requirements
Module: icache_sa

---
 rtl/icache_sa.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational lookup, single-beat line refill,
// age-based LRU replacement and saturating hit/miss performance counters.
module icache_sa #(
  parameter int WAYS  = 2,
  parameter int SETS  = 4,
  parameter int WORDS = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  req,
  input  logic [31:0]           pc,
  input  logic                  flush,
  output logic [31:0]           instr,
  output logic                  hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic [32*WORDS-1:0]   mem_line,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int OFF = $clog2(WORDS) + 2;
  localparam int IW  = $clog2(SETS);
  localparam int TW  = 32 - OFF - IW;
  localparam int WSW = $clog2(WORDS);
  localparam int VW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AW  = VW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state_q, state_d;
  logic [31:0] mem_addr_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  logic [WAYS-1:0]      valid_q [SETS];
  logic [TW-1:0]        tag_q   [WAYS][SETS];
  logic [32*WORDS-1:0]  line_q  [WAYS][SETS];

  logic [IW-1:0]  idx, r_idx, acc_set;
  logic [TW-1:0]  tag, r_tag;
  logic [WSW-1:0] wsel;
  logic [WAYS-1:0] match;
  logic [VW-1:0]  hit_way, victim, lru_way, acc_way;
  logic           one_match, multi_match, found;
  logic           fill, miss_start, acc_en;

  assign idx   = pc[OFF+IW-1:OFF];
  assign tag   = pc[31:OFF+IW];
  assign wsel  = pc[OFF-1:2];
  // The line being refilled is identified solely by the registered refill address.
  assign r_idx = mem_addr_q[OFF+IW-1:OFF];
  assign r_tag = mem_addr_q[31:OFF+IW];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_match
      assign match[gi] = valid_q[idx][gi] && (tag_q[gi][idx] == tag);
    end
  endgenerate

  always_comb begin
    one_match   = 1'b0;
    multi_match = 1'b0;
    hit_way     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (match[w]) begin
        if (one_match) multi_match = 1'b1;
        one_match = 1'b1;
        hit_way   = VW'(w);
      end
    end
  end

  assign hit      = req && (state_q == IDLE) && !flush && one_match && !multi_match;
  assign instr    = hit ? line_q[hit_way][idx][{wsel, 5'd0} +: 32] : NOP;
  assign stall    = (req && !hit) || (state_q == REFILL);
  assign mem_req  = (state_q == REFILL);
  assign mem_addr = mem_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Lowest invalid way wins; LRU is consulted only when the set is full.
  always_comb begin
    victim = lru_way;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[r_idx][w]) begin
        victim = VW'(w);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fill       = 1'b0;
    miss_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !flush && !hit) begin
          state_d    = REFILL;
          miss_start = 1'b1;
        end
      end
      REFILL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          state_d = IDLE;
          fill    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_en  = hit || fill;
  assign acc_set = fill ? r_idx : idx;
  assign acc_way = fill ? victim : hit_way;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      if (miss_start) mem_addr_q <= {pc[31:OFF], {OFF{1'b0}}};
      if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (flush) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (fill) begin
        valid_q[r_idx][victim] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[victim][r_idx]  <= r_tag;
      line_q[victim][r_idx] <= mem_line;
    end
  end

  generate
    if (WAYS > 1) begin : g_lru
      logic [AW-1:0] age_q [SETS][WAYS];
      logic [AW-1:0] old_age;

      always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[r_idx][w] == AW'(WAYS - 1)) lru_way = VW'(w);
        end
        old_age = age_q[acc_set][acc_way];
      end

      // Accessed way becomes youngest; only ways younger than it age by one.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              age_q[s][w] <= AW'(w);
        end else if (acc_en) begin
          for (int w = 0; w < WAYS; w++) begin
            if (VW'(w) == acc_way)
              age_q[acc_set][w] <= '0;
            else if (age_q[acc_set][w] < old_age)
              age_q[acc_set][w] <= age_q[acc_set][w] + 1'b1;
          end
        end
      end
    end else begin : g_no_lru
      assign lru_way = '0;
    end
  endgenerate

endmodule
